// File: rtl/serial_tx_arbiter_pkg.sv
// Shared types and frame-length helper for the serial TX arbiter.
// Optional trailing even-parity bit: SERIAL_TX_ARBITER_PARITY_EN.
package serial_tx_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef SERIAL_TX_ARBITER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int bits_per_word(input int width, input bit parity);
    return parity ? width + 1 : width;
  endfunction

endpackage

// File: rtl/ser_shift_core.sv
// LSB-first shift register with bit counter; flags the final bit of a frame.
// Frame includes the even-parity bit when SERIAL_TX_ARBITER_PARITY_EN is defined.
module ser_shift_core
  import serial_tx_arbiter_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [width-1:0] load_data,
  input  logic             shift,
  output logic             bit_out,
  output logic             last
);

  localparam int BPW = bits_per_word(width, PARITY_EN);
  localparam int CW  = $clog2(BPW + 1);

  logic [BPW-1:0] sr;
  logic [BPW-1:0] frame;
  logic [CW-1:0]  cnt;

  if (PARITY_EN) begin : g_par
    assign frame = {^load_data, load_data};
  end else begin : g_nopar
    assign frame = load_data;
  end

  // Load wins over shift so a back-to-back word replaces the last bit cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= frame;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {1'b0, sr[BPW-1:1]};
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_out = sr[0];
  assign last    = (cnt == CW'(BPW - 1));

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter serialising n_req parallel words onto one LSB-first line.
// Define SERIAL_TX_ARBITER_PARITY_EN to append an even-parity bit per word.
module serial_tx_arbiter
  import serial_tx_arbiter_pkg::*;
#(
  parameter int n_req = 4,
  parameter int width = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [n_req-1:0]           req_valid,
  input  logic [n_req*width-1:0]     req_data,
  output logic [n_req-1:0]           req_ready,
  output logic                       busy,
  output logic                       serial_valid,
  output logic                       serial_data,
  output logic [$clog2(n_req)-1:0]   serial_src
);

  localparam int SRC_W = $clog2(n_req);

  state_t           state, state_nxt;
  logic [SRC_W-1:0] ptr, src, gnt_idx;
  logic             gnt_found, grant, shift, last, bit_out;
  int               j;

  // Rotating search starting at the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = 0; k < n_req; k++) begin
      j = int'(ptr) + k;
      if (j >= n_req) j = j - n_req;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = SRC_W'(j);
      end
    end
  end

  // Grants only from IDLE or on the final bit; held off while reset is asserted.
  assign grant = rst_n && gnt_found && ((state == IDLE) || (state == SHIFT && last));
  assign shift = (state == SHIFT) && !grant;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = SHIFT;
      SHIFT:   if (last && !grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      src <= '0;
    end else if (grant) begin
      src <= gnt_idx;
      ptr <= (int'(gnt_idx) == n_req - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  ser_shift_core #(.width(width)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (grant),
    .load_data (req_data[int'(gnt_idx)*width +: width]),
    .shift     (shift),
    .bit_out   (bit_out),
    .last      (last)
  );

  assign serial_valid = (state == SHIFT);
  assign busy         = serial_valid;
  assign serial_data  = serial_valid & bit_out;
  assign serial_src   = serial_valid ? src : '0;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Randomised + directed bench for serial_tx_arbiter with a queue-based scoreboard.
module tb_serial_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;
`ifdef SERIAL_TX_ARBITER_PARITY_EN
  localparam int BPW = W + 1;
`else
  localparam int BPW = W;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic             busy, serial_valid, serial_data;
  logic [1:0]       serial_src;

  serial_tx_arbiter #(.n_req(N), .width(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .busy(busy), .serial_valid(serial_valid),
    .serial_data(serial_data), .serial_src(serial_src)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining-bit count and RR pointer, evaluated once per cycle.
  int          rem = 0;
  int          ptr = 0;
  logic [W:0]  exp_q[$];
  int          exp_src[$];
  int          gnt_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      rem = 0;
      ptr = 0;
      exp_q.delete();
      exp_src.delete();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_serial_valid", serial_valid, 0);
    end else begin
      int g;
      logic [W-1:0] d;
      logic [W:0]   fr;
      chk("serial_valid", serial_valid, (rem > 0));
      chk("busy", busy, (rem > 0));
      if (rem == 0) begin
        chk("idle_data", serial_data, 0);
        chk("idle_src", serial_src, 0);
      end
      for (int i = 0; i < N; i++) if (req_ready[i]) gnt_log.push_back(i);
      if (rem <= 1 && req_valid != 0) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
        chk("req_ready_grant", req_ready, 64'(1) << g);
        d  = req_data[g*W +: W];
        fr = '0;
        fr[W-1:0] = d;
        if (BPW > W) fr[W] = ^d;
        exp_q.push_back(fr);
        exp_src.push_back(g);
        ptr = (g + 1) % N;
        rem = BPW;
      end else begin
        chk("req_ready_idle", req_ready, 0);
        if (rem > 0) rem--;
      end
    end
  end

  // Monitor: assembles serial bits into frames and checks them against the queue.
  int         nb = 0;
  int         src0 = 0;
  logic [W:0] acc = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      nb = 0;
    end else if (serial_valid) begin
      if (nb == 0) begin
        acc  = '0;
        src0 = int'(serial_src);
      end else begin
        chk("src_hold", serial_src, src0);
      end
      acc[nb] = serial_data;
      nb++;
      if (nb == BPW) begin
        nb = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          chk("word", acc, exp_q.pop_front());
          chk("word_src", src0, exp_src.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_now_valid", serial_valid, 0);
    chk("rst_now_busy", busy, 0);
    chk("rst_now_data", serial_data, 0);
    chk("rst_now_src", serial_src, 0);
    chk("rst_now_ready", req_ready, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grants(input int n);
    int c = 0;
    while (gnt_log.size() < n && c < 200) begin
      tick();
      c++;
    end
    if (gnt_log.size() < n) chk("grant_timeout", gnt_log.size(), n);
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (BPW + 3) tick();
  endtask

  task automatic send_one(input int r, input logic [W-1:0] d);
    req_data[r*W +: W] = d;
    req_valid = '0;
    req_valid[r] = 1'b1;
    tick();
    drain();
  endtask

  initial begin
    int exp_rr[5]   = '{0, 1, 2, 3, 0};
    int exp_skip[4] = '{1, 3, 1, 3};

    tick();
    do_reset();
    repeat (3) tick();

    // Single word and parity-relevant words.
    send_one(0, 8'hA5);
    send_one(0, 8'h07);
    send_one(0, 8'h03);

    // Round-robin with all requesters held valid.
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    gnt_log.delete();
    req_valid = '1;
    wait_grants(5);
    req_valid = '0;
    for (int i = 0; i < 5; i++) chk("rr_order", gnt_log[i], exp_rr[i]);
    drain();

    // Skip idle requesters.
    do_reset();
    gnt_log.delete();
    req_valid = 4'b1010;
    wait_grants(4);
    req_valid = '0;
    for (int i = 0; i < 4; i++) chk("skip_order", gnt_log[i], exp_skip[i]);
    drain();

    // Mid-word reset on bit 3, then priority restarts at requester 0.
    req_data[1*W +: W] = 8'h5A;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (3) tick();
    req_valid = '1;
    gnt_log.delete();
    do_reset();
    gnt_log.delete();
    wait_grants(1);
    chk("post_reset_grant", gnt_log[0], 0);
    drain();

    // Data changing while the word is in flight.
    do_reset();
    req_data[2*W +: W] = 8'h0F;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    req_data[2*W +: W] = 8'hF0;
    drain();

    // Random traffic.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom);
      if ($urandom_range(0, 3) == 0) req_valid = '0;
      req_data = {$urandom, $urandom};
      tick();
    end
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
